// File: rtl/button_conditioner_if.sv
// Push-button conditioner signal bundle: raw button level in, debounced
// level and press/release/long-press event pulses out.
interface button_conditioner_if;
    logic button_i;
    logic press_o;
    logic release_o;
    logic long_o;
    logic level_o;

    modport master (
        output button_i,
        input  press_o,
        input  release_o,
        input  long_o,
        input  level_o
    );

    modport slave (
        input  button_i,
        output press_o,
        output release_o,
        output long_o,
        output level_o
    );
endinterface

// File: rtl/button_conditioner.sv
// Debounces a raw push-button and emits registered press, release and
// long-press pulses plus a debounced level.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned LONG_CYCLES     = 100
) (
    input  logic                 clk,
    input  logic                 nRst_i,
    button_conditioner_if.slave  bus
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state_q;
    logic          s1_q;
    logic          s2_q;
    logic [DW-1:0] deb_q;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          level_q;

    // Saturating hold count so a very long hold can never re-trigger long_o.
    always_comb begin
        hold_d = hold_q;
        if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            s1_q      <= bus.button_i;
            s2_q      <= s1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
                hold_q <= hold_d;
                if (hold_q == HOLD_LAST) begin
                    long_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q <= PRESS_WAIT;
                        deb_q   <= DEB_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_MAX) begin
                        state_q <= PRESSED;
                        deb_q   <= '0;
                        hold_q  <= '0;
                        press_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2_q) begin
                        state_q <= RELEASE_WAIT;
                        deb_q   <= DEB_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    // A short dropout returns to PRESSED; the hold time keeps running.
                    if (s2_q) begin
                        state_q <= PRESSED;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_MAX) begin
                        state_q   <= IDLE;
                        deb_q     <= '0;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    deb_q   <= '0;
                end
            endcase
        end
    end

    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.long_o    = long_q;
    assign bus.level_o   = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed stimulus for button_conditioner, checked every
// cycle against a window-based behavioural model of the debouncer.
module tb_button_conditioner;

    localparam int D    = 2;
    localparam int LONG = 100;

    logic clk;
    logic nRst_i;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk    (clk),
        .nRst_i (nRst_i),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a level change is accepted when the last D+1 synchronized samples
    // (raw input delayed two edges, zero right after reset) all differ from it.
    int   n_edge;
    int   press_edge;
    logic m_lvl;
    logic exp_press, exp_release, exp_long;
    logic raw_hist[$];
    logic sync_hist[$];

    task automatic model_reset();
        n_edge      = 0;
        press_edge  = -1000000;
        m_lvl       = 1'b0;
        exp_press   = 1'b0;
        exp_release = 1'b0;
        exp_long    = 1'b0;
        raw_hist.delete();
        sync_hist.delete();
    endtask

    task automatic model_edge(input logic b);
        logic s;
        logic all_diff;
        raw_hist.push_back(b);
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        s = (raw_hist.size() == 3) ? raw_hist[0] : 1'b0;
        sync_hist.push_back(s);
        if (sync_hist.size() > D + 1) void'(sync_hist.pop_front());
        all_diff = (sync_hist.size() == D + 1);
        foreach (sync_hist[i]) if (sync_hist[i] == m_lvl) all_diff = 1'b0;
        exp_long    = m_lvl && ((n_edge - press_edge) == LONG);
        exp_press   = all_diff && !m_lvl;
        exp_release = all_diff && m_lvl;
        if (all_diff) begin
            m_lvl = ~m_lvl;
            if (m_lvl) press_edge = n_edge;
        end
        n_edge++;
    endtask

    int n_press_seen;
    int n_long_seen;

    task automatic step(input logic b);
        bif.button_i = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        check("press",   bif.press_o,   exp_press);
        check("release", bif.release_o, exp_release);
        check("long",    bif.long_o,    exp_long);
        check("level",   bif.level_o,   m_lvl);
        if (bif.press_o) n_press_seen++;
        if (bif.long_o)  n_long_seen++;
    endtask

    task automatic hold(input logic b, input int cycles);
        for (int i = 0; i < cycles; i++) step(b);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_press"},   bif.press_o,   1'b0);
        check({tag, "_release"}, bif.release_o, 1'b0);
        check({tag, "_long"},    bif.long_o,    1'b0);
        check({tag, "_level"},   bif.level_o,   1'b0);
    endtask

    task automatic do_reset(input int cycles);
        #2 nRst_i = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < cycles; i++) @(negedge clk);
        check_all_zero("in_rst");
        nRst_i = 1'b1;
        model_reset();
    endtask

    initial begin
        nRst_i       = 1'b0;
        bif.button_i = 1'b0;
        n_press_seen = 0;
        n_long_seen  = 0;
        model_reset();
        #1 check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        nRst_i = 1'b1;

        // Clean press with a long hold: one press, exactly one long pulse.
        n_press_seen = 0;
        n_long_seen  = 0;
        hold(1'b1, 250);
        check("long_hold_presses", n_press_seen, 1);
        check("long_hold_longs",   n_long_seen,  1);
        hold(1'b0, 10);
        $display("seg long_hold: presses=%0d longs=%0d", n_press_seen, n_long_seen);

        // Two-sample bounce must be rejected.
        n_press_seen = 0;
        hold(1'b1, 2);
        hold(1'b0, 20);
        check("bounce_presses", n_press_seen, 0);
        $display("seg bounce: presses=%0d", n_press_seen);

        // Press, single-cycle release glitch, then a clean release.
        n_press_seen = 0;
        hold(1'b1, 20);
        step(1'b0);
        hold(1'b1, 20);
        check("glitch_presses", n_press_seen, 1);
        hold(1'b0, 10);
        $display("seg glitch: presses=%0d", n_press_seen);

        // Release coinciding with the long-press edge.
        hold(1'b1, LONG + 2);
        hold(1'b0, 10);
        $display("seg release_at_long: level=%0b", bif.level_o);

        // Reset while held; the held button must be re-accepted afterwards.
        n_press_seen = 0;
        hold(1'b1, 30);
        bif.button_i = 1'b1;
        do_reset(3);
        hold(1'b1, 10);
        check("rst_reaccept_presses", n_press_seen, 2);
        hold(1'b0, 10);
        $display("seg reset_mid_hold: presses=%0d", n_press_seen);

        for (int seg = 0; seg < 40; seg++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    len = $urandom_range(1, 130);
                    hold(1'b1, len);
                    hold(1'b0, $urandom_range(1, 10));
                end
                1: begin
                    len = $urandom_range(3, 10);
                    for (int i = 0; i < len; i++) step(1'($urandom_range(0, 1)));
                end
                2: begin
                    len = $urandom_range(1, 20);
                    hold(1'b0, len);
                end
                3: begin
                    len = $urandom_range(1, 3);
                    hold(1'b1, 8);
                    hold(1'b0, len);
                    hold(1'b1, 8);
                end
                default: begin
                    len = $urandom_range(1, 40);
                    hold(1'b1, len);
                    bif.button_i = 1'($urandom_range(0, 1));
                    do_reset($urandom_range(1, 3));
                end
            endcase
            $display("seg %0d kind=%0d len=%0d level=%0b", seg, kind, len, bif.level_o);
        end

        hold(1'b0, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2, meaning the number of extra consecutive stable synchronized samples (D) required to accept a level change; legal range 1..255.
REQ-002 Parameter LONG_CYCLES, default 100, meaning the number of cycles after press acceptance before a long-press pulse is issued (1 s at hz100); legal range 2..65535.
REQ-003 Port clk, input, 1 bit: single clock (hz100 domain); all state changes on the rising edge.
REQ-004 Port nRst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port button_i, input, 1 bit: raw asynchronous push-button level (pb[n]); high means pressed.
REQ-006 Port press_o, output, 1 bit: one-cycle pulse on accepted press; feeds stop_watch button_i.
REQ-007 Port release_o, output, 1 bit: one-cycle pulse on accepted release.
REQ-008 Port long_o, output, 1 bit: one-cycle pulse when the accepted press has been held LONG_CYCLES cycles.
REQ-009 Port level_o, output, 1 bit: debounced button level.

Function
REQ-010 button_i SHALL pass through a two-flop synchronizer (s1, then s2); only s2 drives the FSM.
REQ-011 The FSM SHALL have exactly 4 states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE: if s2=1, go to PRESS_WAIT with debounce count=1; otherwise stay.
REQ-013 PRESS_WAIT: if s2=0, return to IDLE with count=0 and no output; if s2=1 and count==D, go to PRESSED; otherwise increment count.
REQ-014 PRESSED: if s2=0, go to RELEASE_WAIT with count=1; otherwise stay.
REQ-015 RELEASE_WAIT: if s2=1, return to PRESSED with no pulse, and the hold counter continues; if s2=0 and count==D, go to IDLE; otherwise increment count.
REQ-016 press_o SHALL be registered and high for exactly the one cycle following the PRESS_WAIT->PRESSED edge.
REQ-017 release_o SHALL be registered and high for exactly the one cycle following the RELEASE_WAIT->IDLE edge.
REQ-018 Latency, clean input: with the first edge sampling button_i high called edge 0, press_o SHALL rise at edge D+2; release latency SHALL be symmetric.
REQ-019 level_o SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT; it is registered with the state.
REQ-020 Hold counter: cleared on entering PRESSED from PRESS_WAIT; incremented each cycle in PRESSED or RELEASE_WAIT; saturates at LONG_CYCLES; never wraps.
REQ-021 long_o SHALL pulse once, at the edge where the hold counter reaches LONG_CYCLES (press_o edge + LONG_CYCLES); no repeat until the next accepted press.
REQ-022 Simultaneous events: long_o and release_o MAY assert in the same cycle; press_o SHALL never coincide with release_o or long_o.
REQ-023 Counter widths SHALL be $clog2(D+1) for the debounce count and $clog2(LONG_CYCLES+1) for the hold counter; no overflow for any legal parameter value.
REQ-024 A bounce shorter than D+1 synchronized samples SHALL produce no pulse and no level_o change.

Reset
REQ-025 When nRst_i=0, the block SHALL immediately set s1=s2=0, state=IDLE, both counters=0, and press_o=release_o=long_o=level_o=0.
REQ-026 Reset asserted mid-press SHALL emit no release_o; after reset deassertion, a button still held SHALL be re-accepted via PRESS_WAIT with a fresh press_o.

Verification (D=2, LONG_CYCLES=100)
REQ-027 Clean press: button_i=1 from edge 0 -> press_o high only in the cycle after edge 4; level_o=1 from edge 4.
REQ-028 Bounce: button_i=1 for edges 0-1, then 0 -> press_o, level_o and long_o stay 0 for 20 cycles.
REQ-029 Release: pressed, then button_i=0 from edge 50 -> release_o single pulse at edge 54; level_o=0 from edge 54.
REQ-030 Release glitch: while pressed, button_i=0 for 1 cycle -> no release_o, level_o stays 1, and no second press_o.
REQ-031 Long hold: button_i=1 for 250 cycles -> press_o at edge 4, long_o exactly once at edge 104, and no further long_o.
REQ-032 Reset mid-hold: nRst_i low at edge 30 with button held -> all outputs 0 asynchronously; after release of reset, press_o fires D+2 edges later.
